// File: rtl/cpu_ctrl_pkg.sv
// Purpose : shared opcode, control-bit and decode-table definitions for the CPU control pipeline.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: opcode_e, control bit indices, ctrl_word_t, per-opcode decode tables and source-usage masks.
package cpu_ctrl_pkg;

    localparam int CTRL_BITS  = 6;
    localparam int ALUOP_BITS = 2;
    localparam int REG_BITS   = 3;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_ADDI = 4'h4,
        OP_LW   = 4'h5,
        OP_SW   = 4'h6,
        OP_BEQ  = 4'h7
    } opcode_e;

    // Control word bit positions.
    localparam int CB_REG_WRITE   = 0;
    localparam int CB_MEM_READ    = 1;
    localparam int CB_MEM_WRITE   = 2;
    localparam int CB_ALU_SRC_IMM = 3;
    localparam int CB_MEM_TO_REG  = 4;
    localparam int CB_BRANCH      = 5;

    typedef struct packed {
        logic [CTRL_BITS-1:0]  ctrl;
        logic [ALUOP_BITS-1:0] alu_op;
        logic [REG_BITS-1:0]   rd;
        logic                  valid;
    } ctrl_word_t;

    // Decode tables indexed by the low three opcode bits (legal opcodes 0..7).
    localparam logic [CTRL_BITS-1:0] CTRL_TBL [0:7] = '{
        6'b000000,  // NOP
        6'b000001,  // ADD
        6'b000001,  // SUB
        6'b000001,  // AND
        6'b001001,  // ADDI
        6'b011011,  // LW
        6'b001100,  // SW
        6'b100000   // BEQ
    };

    localparam logic [ALUOP_BITS-1:0] ALUOP_TBL [0:7] = '{
        2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01
    };

    // Bit i set = opcode i reads that source register.
    localparam logic [7:0] USES_RS_MASK = 8'b1111_1110;
    localparam logic [7:0] USES_RT_MASK = 8'b1100_1110;

endpackage

// File: rtl/instr_decoder.sv
// Purpose : decode an instruction word into a control word plus source-register usage.
// Latency : purely combinational.
// Backpressure: none; output follows ir.
// Ports   : ir in; cw (ctrl_word_t), rs, rt, uses_rs, uses_rt, illegal out.
module instr_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0]  ir,
    output ctrl_word_t          cw,
    output logic [REG_BITS-1:0] rs,
    output logic [REG_BITS-1:0] rt,
    output logic                uses_rs,
    output logic                uses_rt,
    output logic                illegal
);

    opcode_e    op;
    logic [2:0] idx;
    logic       unused_imm;

    assign op         = opcode_e'(ir[15:12]);
    assign idx        = ir[14:12];
    assign rs         = ir[8:6];
    assign rt         = ir[5:3];
    assign unused_imm = ^ir[2:0];

    always_comb begin
        cw      = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
                cw.ctrl   = CTRL_TBL[idx];
                cw.alu_op = ALUOP_TBL[idx];
                cw.rd     = ir[11:9];
                cw.valid  = 1'b1;
                uses_rs   = USES_RS_MASK[idx];
                uses_rt   = USES_RT_MASK[idx];
            end
            // Unknown opcodes decode to a bubble (all-zero cw).
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Purpose : decode, load-use hazard detection and STAGES-deep control shift register for the CPU.
// Latency : ir accepted at edge n sits in stage k after edge n+k; one instruction per cycle.
// Backpressure: in_ready drops for exactly one cycle on a load-use hazard unless flush is high.
// Ports   : clk/reset; ir, in_valid, flush in; in_ready, stall comb out; ctrl_bus, rd_bus,
//           stage_valid, alu_op, illegal_op, stall_count registered out. STAGES legal range 2..8.
module ctrl_pipeline
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int CTRL_W  = 6,
    parameter int ALUOP_W = 2,
    parameter int REG_W   = 3,
    parameter int STAGES  = 3,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INSTR_W-1:0]         ir,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [STAGES*CTRL_W-1:0]   ctrl_bus,
    output logic [STAGES*REG_W-1:0]    rd_bus,
    output logic [STAGES-1:0]          stage_valid,
    output logic [ALUOP_W-1:0]         alu_op,
    output logic                       stall,
    output logic                       illegal_op,
    output logic [CNT_W-1:0]           stall_count
);

    ctrl_word_t          dec_cw;
    logic [REG_BITS-1:0] dec_rs;
    logic [REG_BITS-1:0] dec_rt;
    logic                dec_uses_rs;
    logic                dec_uses_rt;
    logic                dec_illegal;

    instr_decoder #(.INSTR_W(INSTR_W)) u_dec (
        .ir      (ir),
        .cw      (dec_cw),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .uses_rs (dec_uses_rs),
        .uses_rt (dec_uses_rt),
        .illegal (dec_illegal)
    );

    logic [CTRL_W-1:0]  ctrl_q [STAGES];
    logic [REG_W-1:0]   rd_q   [STAGES];
    logic [STAGES-1:0]  vld_q;
    logic [ALUOP_W-1:0] alu_q;
    logic               illegal_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [CTRL_W-1:0]  ctrl0_d;
    logic [REG_W-1:0]   rd0_d;
    logic               vld0_d;
    logic [ALUOP_W-1:0] alu_d;
    logic               illegal_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               take;
    logic               rs_hit;
    logic               rt_hit;

    // Load-use: the load in EX cannot forward to an instruction decoding now.
    always_comb begin
        rs_hit   = dec_uses_rs && (rd_q[0] == REG_W'(dec_rs));
        rt_hit   = dec_uses_rt && (rd_q[0] == REG_W'(dec_rt));
        stall    = in_valid && vld_q[0] && ctrl_q[0][CB_MEM_READ] &&
                   (rd_q[0] != '0) && (rs_hit || rt_hit);
        // A flushed instruction is consumed even while a stall would be raised.
        in_ready = !reset && (!stall || flush);
        take     = in_valid && !flush && !stall;
    end

    // Stage-0 next state; an illegal opcode already decodes to all-zero fields.
    always_comb begin
        ctrl0_d   = '0;
        rd0_d     = '0;
        vld0_d    = 1'b0;
        alu_d     = '0;
        illegal_d = 1'b0;
        cnt_d     = cnt_q;
        if (take) begin
            ctrl0_d   = CTRL_W'(dec_cw.ctrl);
            rd0_d     = REG_W'(dec_cw.rd);
            vld0_d    = dec_cw.valid;
            alu_d     = ALUOP_W'(dec_cw.alu_op);
            illegal_d = dec_illegal;
        end
        if (stall && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                rd_q[k]   <= '0;
            end
            vld_q     <= '0;
            alu_q     <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q[0] <= ctrl0_d;
            rd_q[0]   <= rd0_d;
            vld_q[0]  <= vld0_d;
            // Older instructions always drain, even during a stall.
            for (int k = 1; k < STAGES; k++) begin
                ctrl_q[k] <= ctrl_q[k-1];
                rd_q[k]   <= rd_q[k-1];
                vld_q[k]  <= vld_q[k-1];
            end
            alu_q     <= alu_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_bus
        assign ctrl_bus[k*CTRL_W +: CTRL_W] = ctrl_q[k];
        assign rd_bus[k*REG_W +: REG_W]     = rd_q[k];
    end

    assign stage_valid = vld_q;
    assign alu_op      = alu_q;
    assign illegal_op  = illegal_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Purpose : directed self-checking bench for ctrl_pipeline (default build plus a 2-bit counter build).
// Latency : inputs change 1 time unit after a rising edge; outputs sampled there too.
// Backpressure: stall/in_ready checked with the dependent instruction presented.
module tb_ctrl_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir;
    logic        in_valid;
    logic        flush;

    logic        in_ready;
    logic [17:0] ctrl_bus;
    logic [8:0]  rd_bus;
    logic [2:0]  stage_valid;
    logic [1:0]  alu_op;
    logic        stall;
    logic        illegal_op;
    logic [15:0] stall_count;

    logic        s_in_ready;
    logic [17:0] s_ctrl_bus;
    logic [8:0]  s_rd_bus;
    logic [2:0]  s_stage_valid;
    logic [1:0]  s_alu_op;
    logic        s_stall;
    logic        s_illegal_op;
    logic [1:0]  s_stall_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ctrl_pipeline u_dut (
        .clk         (clk),
        .reset       (reset),
        .ir          (ir),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .ctrl_bus    (ctrl_bus),
        .rd_bus      (rd_bus),
        .stage_valid (stage_valid),
        .alu_op      (alu_op),
        .stall       (stall),
        .illegal_op  (illegal_op),
        .stall_count (stall_count)
    );

    ctrl_pipeline #(.CNT_W(2)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .ir          (ir),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .flush       (flush),
        .ctrl_bus    (s_ctrl_bus),
        .rd_bus      (s_rd_bus),
        .stage_valid (s_stage_valid),
        .alu_op      (s_alu_op),
        .stall       (s_stall),
        .illegal_op  (s_illegal_op),
        .stall_count (s_stall_count)
    );

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        ir       = '0;
        in_valid = 1'b0;
        flush    = 1'b0;

        // Power-on reset.
        tick(); tick();
        chk("rst_ctrl", 32'(ctrl_bus), 32'h0);
        chk("rst_rd", 32'(rd_bus), 32'h0);
        chk("rst_valid", 32'(stage_valid), 32'h0);
        chk("rst_alu", 32'(alu_op), 32'h0);
        chk("rst_illegal", 32'(illegal_op), 32'h0);
        chk("rst_cnt", 32'(stall_count), 32'h0);

        // ADD r1,r2,r3 enters, then reset for two cycles drops it.
        reset    = 1'b0;
        ir       = ins(4'h1, 3'd1, 3'd2, 3'd3);
        in_valid = 1'b1;
        tick();
        chk("pre_rst_valid", 32'(stage_valid), 32'h1);
        chk("pre_rst_ctrl0", 32'(ctrl_bus[5:0]), 32'h01);
        reset = 1'b1;
        tick(); tick();
        chk("midrst_ctrl", 32'(ctrl_bus), 32'h0);
        chk("midrst_rd", 32'(rd_bus), 32'h0);
        chk("midrst_valid", 32'(stage_valid), 32'h0);
        chk("midrst_alu", 32'(alu_op), 32'h0);
        chk("midrst_cnt", 32'(stall_count), 32'h0);

        // ADD then SUB back to back.
        reset = 1'b0;
        ir    = ins(4'h1, 3'd1, 3'd2, 3'd3);
        #1;
        chk("add_stall", 32'(stall), 32'h0);
        chk("add_ready", 32'(in_ready), 32'h1);
        tick();
        chk("add_valid", 32'(stage_valid), 32'h1);
        chk("add_ctrl", 32'(ctrl_bus), 32'h00001);
        chk("add_alu", 32'(alu_op), 32'h0);
        ir = ins(4'h2, 3'd4, 3'd5, 3'd6);
        #1;
        chk("sub_stall", 32'(stall), 32'h0);
        tick();
        chk("sub_valid", 32'(stage_valid), 32'h3);
        chk("sub_ctrl", 32'(ctrl_bus), 32'h00041);
        chk("sub_alu", 32'(alu_op), 32'h1);
        chk("sub_rd", 32'(rd_bus), 32'h00C);
        in_valid = 1'b0;
        tick();
        chk("add_s2_valid", 32'(stage_valid), 32'h6);
        chk("add_s2_rd", 32'(rd_bus[8:6]), 32'h1);
        chk("add_s2_ctrl", 32'(ctrl_bus[17:12]), 32'h01);
        chk("nostall_cnt", 32'(stall_count), 32'h0);
        tick(); tick();
        chk("drained", 32'(stage_valid), 32'h0);

        // LW r2,r1 then dependent ADD r3,r2,r4: one stall cycle.
        ir       = ins(4'h5, 3'd2, 3'd1, 3'd0);
        in_valid = 1'b1;
        tick();
        chk("lw_ctrl", 32'(ctrl_bus[5:0]), 32'h1B);
        ir = ins(4'h1, 3'd3, 3'd2, 3'd4);
        #1;
        chk("lu_stall", 32'(stall), 32'h1);
        chk("lu_ready", 32'(in_ready), 32'h0);
        tick();
        chk("lu_bubble", 32'(stage_valid), 32'h2);
        chk("lu_cnt", 32'(stall_count), 32'h1);
        chk("lu_stall_gone", 32'(stall), 32'h0);
        chk("lu_ready_back", 32'(in_ready), 32'h1);
        tick();
        chk("lu_add_valid", 32'(stage_valid), 32'h5);
        chk("lu_add_ctrl", 32'(ctrl_bus[5:0]), 32'h01);
        chk("lu_add_rd", 32'(rd_bus[2:0]), 32'h3);

        // LW r2 then independent ADD r3,r5,r6.
        ir = ins(4'h5, 3'd2, 3'd1, 3'd0);
        tick();
        ir = ins(4'h1, 3'd3, 3'd5, 3'd6);
        #1;
        chk("indep_stall", 32'(stall), 32'h0);
        tick();
        chk("indep_valid", 32'(stage_valid[1:0]), 32'h3);
        chk("indep_cnt", 32'(stall_count), 32'h1);

        // LW r0 then ADD r3,r0,r0: r0 never creates a hazard.
        ir = ins(4'h5, 3'd0, 3'd1, 3'd0);
        tick();
        ir = ins(4'h1, 3'd3, 3'd0, 3'd0);
        #1;
        chk("r0_stall", 32'(stall), 32'h0);
        tick();

        // Flush while a load-use hazard is presented.
        ir = ins(4'h5, 3'd2, 3'd1, 3'd0);
        tick();
        ir    = ins(4'h1, 3'd3, 3'd2, 3'd4);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'h1);
        chk("fl_ready", 32'(in_ready), 32'h1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(stage_valid[1:0]), 32'h2);
        chk("fl_lw_s1", 32'(ctrl_bus[11:6]), 32'h1B);
        chk("fl_cnt", 32'(stall_count), 32'h1);

        // Illegal opcode: one-cycle pulse, bubble in stage 0.
        ir       = 16'hF000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill_pulse", 32'(illegal_op), 32'h1);
        chk("ill_valid0", 32'(stage_valid[0]), 32'h0);
        chk("ill_ctrl0", 32'(ctrl_bus[5:0]), 32'h0);
        tick();
        chk("ill_pulse_end", 32'(illegal_op), 32'h0);

        // SW and BEQ decode.
        ir       = ins(4'h6, 3'd1, 3'd2, 3'd3);
        in_valid = 1'b1;
        tick();
        chk("sw_ctrl", 32'(ctrl_bus[5:0]), 32'h0C);
        chk("sw_alu", 32'(alu_op), 32'h0);
        ir = ins(4'h7, 3'd0, 3'd2, 3'd3);
        tick();
        chk("beq_ctrl", 32'(ctrl_bus[5:0]), 32'h20);
        chk("beq_alu", 32'(alu_op), 32'h1);

        // Four more load-use stalls: total 5, 2-bit counter saturates at 3.
        chk("sat_pre", 32'(s_stall_count), 32'h1);
        for (int i = 0; i < 4; i++) begin
            ir = ins(4'h5, 3'd2, 3'd1, 3'd0);
            tick();
            ir = ins(4'h1, 3'd3, 3'd2, 3'd4);
            tick();
            tick();
        end
        in_valid = 1'b0;
        chk("cnt_five", 32'(stall_count), 32'h5);
        chk("sat_three", 32'(s_stall_count), 32'h3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Parametrised control pipeline for the 16-bit pipelined CPU; next generation of the fixed 6-bit `ctrl_bus` / `alu_op` register pair.
- Decodes the incoming instruction word into a control word plus ALU op.
- Carries the control word through `STAGES` registered pipeline stages (stage 0 = EX) with stage-valid bits.
- Detects load-use hazards, inserts bubbles and honours a branch flush; the data path consumes the per-stage control fields.

Parameters:
- INSTR_W, 16, instruction word width.
- CTRL_W, 6, control word width; bit order fixed in the package.
- ALUOP_W, 2, ALU operation field width.
- REG_W, 3, register address width (8 registers, r0 reads zero).
- STAGES, 3, number of control stages after decode (EX, MEM, WB); legal range 2..8.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ir  in  INSTR_W  instruction word from fetch.
- in_valid  in  1  ir is valid this cycle.
- in_ready  out  1  combinational; ir accepted this cycle.
- flush  in  1  branch taken; discard the presented instruction.
- ctrl_bus  out  STAGES*CTRL_W  stage k control word at [k*CTRL_W +: CTRL_W].
- rd_bus  out  STAGES*REG_W  stage k destination register.
- stage_valid  out  STAGES  stage k holds a real instruction.
- alu_op  out  ALUOP_W  ALU op of stage 0.
- stall  out  1  combinational load-use stall.
- illegal_op  out  1  registered one-cycle pulse.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: clk and reset only, one clock domain. Synchronous, active-high reset clears every stage:
  - `ctrl_bus` = 0, `rd_bus` = 0, `stage_valid` = 0, `alu_op` = 0.
  - `illegal_op` = 0, `stall_count` = 0.
  - Reset asserted mid-operation drops all in-flight instructions. No instruction is accepted in a reset cycle.
- Fields: op = ir[15:12], rd = ir[11:9], rs = ir[8:6], rt = ir[5:3].
- Control bits: 0 reg_write, 1 mem_read, 2 mem_write, 3 alu_src_imm, 4 mem_to_reg, 5 branch.
- Decode (ctrl / alu_op / sources used):
  - NOP 0000: 000000 / 00 / none.
  - ADD 0001: 000001 / 00 / rs, rt.
  - SUB 0010: 000001 / 01 / rs, rt.
  - AND 0011: 000001 / 10 / rs, rt.
  - ADDI 0100: 001001 / 00 / rs.
  - LW 0101: 011011 / 00 / rs.
  - SW 0110: 001100 / 00 / rs, rt.
  - BEQ 0111: 100000 / 01 / rs, rt.
  - Any other opcode: decoded as a bubble with `stage_valid` = 0, and `illegal_op` pulses the next cycle.
- Hazard: `stall` = in_valid & stage_valid[0] & ctrl0.mem_read & rd0 != 0 & (rd0 == rs with rs used, or rd0 == rt with rt used).
  - A load-use stall always lasts exactly 1 cycle, because the LW moves on to stage 1.
- `in_ready` = !stall | flush.
- Per clock, priority order:
  1. reset.
  2. flush: stage 0 loads a bubble; the presented ir is consumed and discarded; no stall is counted.
  3. stall: stage 0 loads a bubble; ir is held; `stall_count` increments, saturating at all-ones.
  4. in_valid: stage 0 loads decode(ir); `stage_valid[0]` = 1 if the opcode is legal.
  5. Otherwise: stage 0 loads a bubble.
- In every non-reset cycle, stage k loads stage k-1 for k = 1..STAGES-1, so older instructions always drain.
- A bubble is ctrl = 0, rd = 0, valid = 0.
- Latency: ir accepted at edge n appears in stage k after edge n+k.
- Full throughput: one instruction per cycle when there are no hazards.

Decomposition:
- Package `cpu_ctrl_pkg` holds:
  - the opcode enum;
  - the ctrl bit index constants;
  - a `ctrl_word_t` struct (ctrl, alu_op, rd, valid);
  - the decode constant table and the source-usage masks.
- One combinational sub-module `instr_decoder` (ir -> ctrl_word_t, uses_rs, uses_rt, illegal).
- The stage shift register, hazard logic and counter live in `ctrl_pipeline`.

Test Plan:
- Reset mid-stream, with reset high for 2 cycles after ADD r1,r2,r3 -> all outputs 0, `stall_count` = 0, next accepted instruction reaches stage 0 after 1 edge.
- ADD r1,r2,r3 then SUB r4,r5,r6 back to back -> stage 0 ctrl = 000001 with `alu_op` 00, then 000001 with 01; ADD reaches stage 2 after 3 edges; `stall` never asserted.
- LW r2,r1 then ADD r3,r2,r4 -> 1 stall cycle with `in_ready` = 0, bubble in stage 0, ADD enters one cycle late, `stall_count` = 1; LW r2 then ADD r3,r5,r6 -> no stall.
- LW r0 then ADD r3,r0,r0 -> no stall (r0 excluded).
- LW r2 in stage 0 with dependent ADD presented and flush = 1 in the same cycle -> `in_ready` = 1, ADD discarded, `stall_count` unchanged, LW advances to stage 1.
- Opcode 1111 presented -> `illegal_op` = 1 for exactly one cycle, `stage_valid[0]` = 0; with CNT_W = 2 and 5 stalls, `stall_count` saturates at 3.
